// File: rtl/fifo_push_arbiter_if.sv
// Push-side bundle between N_REQ producers, the FIFO full flag and the push arbiter.
// The master side drives requests/data/full; the slave side (the arbiter) drives grant and push.
interface fifo_push_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 16
);
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    last;
  logic [N_REQ*DW-1:0] data_in;
  logic                full;
  logic [N_REQ-1:0]    gnt;
  logic                push;
  logic [DW-1:0]       push_data;
  logic [IW-1:0]       owner;
  logic                busy;

  modport master (
    output req, last, data_in, full,
    input  gnt, push, push_data, owner, busy
  );

  modport slave (
    input  req, last, data_in, full,
    output gnt, push, push_data, owner, busy
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among N_REQ producers.
// A winner keeps the port for a burst of at most MAX_BURST beats, then re-arbitrates.
module fifo_push_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_push_arbiter_if.slave bus
);
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_ptr, w_ptr_nxt;
  logic [IW-1:0]    r_owner, w_owner_nxt;
  logic [CW-1:0]    r_beat_cnt, w_beat_cnt_nxt;
  logic [IW-1:0]    w_winner;
  logic [IW-1:0]    w_idx;
  logic             w_found;
  logic             w_req_own;
  logic             w_last_own;
  logic             w_cap;
  logic             w_push;
  logic [N_REQ-1:0] w_gnt;
  logic [DW-1:0]    w_slice [N_REQ];

  // Rotating priority search: first requester strictly after r_ptr wins
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_idx = IW'((32'(r_ptr) + k) % N_REQ);
      if (!w_found && bus.req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_slice[i] = bus.data_in[i*DW +: DW];
    end
  end

  assign w_req_own  = bus.req[r_owner];
  assign w_last_own = bus.last[r_owner];
  assign w_cap      = (r_beat_cnt == CW'(MAX_BURST - 1));

  // Next-state and grant/push decode
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    w_gnt          = '0;
    w_push         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !bus.full) begin
          w_owner_nxt    = w_winner;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = S_BURST;
        end
      end
      S_BURST: begin
        w_gnt[r_owner] = !bus.full;
        w_push         = !bus.full && w_req_own;
        // Withdrawal takes priority over a stall on full
        if (!w_req_own) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = r_owner;
        end else if (w_push) begin
          w_beat_cnt_nxt = r_beat_cnt + CW'(1);
          if (w_last_own || w_cap) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = r_owner;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= IW'(N_REQ - 1);
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.push      = w_push;
  assign bus.push_data = w_slice[r_owner];
  assign bus.owner     = r_owner;
  assign bus.busy      = (r_state == S_BURST);
endmodule
